i2c_slave_rx: RTL and testbench

I2C_SLAVE_RX -- requirements
Module: i2c_slave_rx

---
 rtl/i2c_slave_rx.sv | 202 ++++++++++++++++++++
 tb/tb_i2c_slave_rx.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_rx.sv
// I2C slave receiver/transmitter: synchronised, sample_en-gated SCL/SDA, START/STOP detect,
// address match, write-byte reception and read-byte transmission with ACK handling.
module i2c_slave_rx #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       sample_en,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_load,
  output logic       busy,
  output logic       addr_hit
);

  localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
  } state_e;

  logic [NS-1:0] scl_sync_q, sda_sync_q;
  logic          scl_prev_q, sda_prev_q;
  logic          scl_s, sda_s;
  logic          scl_rise, scl_fall, start_c, stop_c;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [6:0] sh_q, sh_d;
  logic [6:0] tx_q, tx_d;
  logic       rw_q, rw_d;
  logic       ack_q, ack_d;       // second half of an ACK slot / master ACK seen
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       addr_hit_q, addr_hit_d;
  logic [7:0] new_byte;

  // Lines idle high, so the chains reset to 1 to avoid a false edge after reset.
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else if (sample_en) begin
      scl_sync_q <= {scl_sync_q[NS-2:0], scl_in};
      sda_sync_q <= {sda_sync_q[NS-2:0], sda_in};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_s    = scl_sync_q[NS-1];
  assign sda_s    = sda_sync_q[NS-1];
  assign scl_rise = sample_en &  scl_s & ~scl_prev_q;
  assign scl_fall = sample_en & ~scl_s &  scl_prev_q;
  assign start_c  = sample_en &  scl_s &  sda_prev_q & ~sda_s;
  assign stop_c   = sample_en &  scl_s & ~sda_prev_q &  sda_s;
  assign new_byte = {sh_q, sda_s};

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sh_q       <= '0;
      tx_q       <= '0;
      rw_q       <= 1'b0;
      ack_q      <= 1'b0;
      sda_oe_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      addr_hit_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      tx_q       <= tx_d;
      rw_q       <= rw_d;
      ack_q      <= ack_d;
      sda_oe_q   <= sda_oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      addr_hit_q <= addr_hit_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    tx_d       = tx_q;
    rw_d       = rw_q;
    ack_d      = ack_q;
    sda_oe_d   = sda_oe_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    addr_hit_d = 1'b0;
    tx_load    = 1'b0;
    // Bus conditions win over any SCL edge seen in the same sample.
    if (stop_c) begin
      state_d  = IDLE;
      cnt_d    = '0;
      ack_d    = 1'b0;
      sda_oe_d = 1'b0;
    end else if (start_c) begin
      state_d  = ADDR;
      cnt_d    = '0;
      ack_d    = 1'b0;
      sda_oe_d = 1'b0;
    end else begin
      unique case (state_q)
        ADDR: if (scl_rise) begin
          sh_d = new_byte[6:0];
          if (cnt_q == 4'd7) begin
            cnt_d = '0;
            rw_d  = sda_s;
            if (new_byte[7:1] == SLAVE_ADDR) begin
              state_d    = ADDR_ACK;
              addr_hit_d = 1'b1;
            end else begin
              state_d = IGNORE;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        ADDR_ACK, WR_ACK: if (scl_fall) begin
          if (!ack_q) begin
            sda_oe_d = 1'b1;
            ack_d    = 1'b1;
          end else begin
            ack_d = 1'b0;
            if (state_q == ADDR_ACK && rw_q) begin
              state_d  = RD_DATA;
              tx_load  = 1'b1;
              tx_d     = tx_data[6:0];
              sda_oe_d = ~tx_data[7];
            end else begin
              state_d  = WR_DATA;
              sda_oe_d = 1'b0;
            end
          end
        end
        WR_DATA: if (scl_rise) begin
          sh_d = new_byte[6:0];
          if (cnt_q == 4'd7) begin
            cnt_d      = '0;
            rx_data_d  = new_byte;
            rx_valid_d = 1'b1;
            state_d    = WR_ACK;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        RD_DATA: begin
          if (scl_rise) begin
            if (cnt_q == 4'd7) begin
              cnt_d   = '0;
              state_d = RD_ACK;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else if (scl_fall) begin
            sda_oe_d = ~tx_q[6];
            tx_d     = {tx_q[5:0], 1'b0};
          end
        end
        RD_ACK: begin
          if (scl_fall) begin
            if (ack_q) begin
              ack_d    = 1'b0;
              state_d  = RD_DATA;
              tx_load  = 1'b1;
              tx_d     = tx_data[6:0];
              sda_oe_d = ~tx_data[7];
            end else begin
              sda_oe_d = 1'b0;
            end
          end else if (scl_rise) begin
            if (sda_s) state_d = IGNORE;
            else       ack_d   = 1'b1;
          end
        end
        IGNORE:  sda_oe_d = 1'b0;
        default: sda_oe_d = 1'b0;
      endcase
    end
  end

  assign sda_oe   = sda_oe_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign addr_hit = addr_hit_q;
  assign busy     = (state_q != IDLE) && (state_q != IGNORE);

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Scoreboard bench for i2c_slave_rx: a bit-banged master drives the bus, expected
// addr_hit / rx_valid / tx_load events are queued and checked by a separate monitor.
module tb_i2c_slave_rx;

  localparam int Q = 6;
  localparam int EV_ADDR = 0, EV_RX = 1, EV_LOAD = 2;

  typedef struct { int kind; logic [7:0] data; } ev_t;

  logic       sys_clk = 1'b0;
  logic       reset;
  logic       sample_en;
  logic       scl_m, sda_m;
  logic [7:0] tx_data;
  logic       sda_oe, rx_valid, tx_load, busy, addr_hit;
  logic [7:0] rx_data;
  logic       sda_line;
  logic       oe_seen;

  ev_t evq[$];
  int  tests = 0;
  int  fails = 0;

  assign sda_line = sda_m & ~sda_oe;

  i2c_slave_rx #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .sys_clk(sys_clk), .reset(reset), .sample_en(sample_en),
    .scl_in(scl_m), .sda_in(sda_line), .sda_oe(sda_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
    .tx_load(tx_load), .busy(busy), .addr_hit(addr_hit)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic push(input int k, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    evq.push_back(e);
  endtask

  task automatic see(input int k, input logic [7:0] d, input string nm);
    ev_t e;
    tests++;
    if (evq.size() == 0) begin
      fails++;
      $display("FAIL %s unexpected: got data %h, required no event", nm, d);
    end else begin
      e = evq.pop_front();
      if (e.kind != k || e.data != d) begin
        fails++;
        $display("FAIL %s: got kind %0d data %h, required kind %0d data %h",
                 nm, k, d, e.kind, e.data);
      end
    end
  endtask

  // Monitor: consumes expected events whenever the DUT presents a pulse.
  always @(negedge sys_clk) begin
    if (reset) begin
      if (addr_hit) see(EV_ADDR, 8'h00, "addr_hit");
      if (rx_valid) see(EV_RX, rx_data, "rx_valid");
      if (tx_load)  see(EV_LOAD, tx_data, "tx_load");
    end
    if (sda_oe) oe_seen = 1'b1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; cyc(Q);
    scl_m = 1'b1; cyc(Q);
    sda_m = 1'b0; cyc(Q);
    scl_m = 1'b0; cyc(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; cyc(Q);
    scl_m = 1'b1; cyc(Q);
    sda_m = 1'b1; cyc(Q);
  endtask

  task automatic clk_bit(input logic b, output logic r);
    sda_m = b;    cyc(Q);
    scl_m = 1'b1; cyc(Q);
    r = sda_line;
    scl_m = 1'b0; cyc(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, input logic exp_ack, input string nm);
    logic r;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], r);
    clk_bit(1'b1, r);
    chk(nm, {31'd0, r}, {31'd0, exp_ack});
  endtask

  task automatic read_byte(input logic [7:0] exp, input logic ack, input string nm);
    logic       r;
    logic [7:0] got;
    got = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, r);
      got[i] = r;
    end
    chk(nm, {24'd0, got}, {24'd0, exp});
    clk_bit(ack, r);
  endtask

  initial begin
    logic r;
    logic [7:0] nib;
    reset = 1'b0; sample_en = 1'b1; scl_m = 1'b1; sda_m = 1'b1; tx_data = 8'h00;
    oe_seen = 1'b0;
    cyc(3);
    chk("reset sda_oe",  {31'd0, sda_oe}, 32'd0);
    chk("reset rx_data", {24'd0, rx_data}, 32'd0);
    chk("reset pulses",  {29'd0, rx_valid, tx_load, addr_hit}, 32'd0);
    chk("reset busy",    {31'd0, busy}, 32'd0);
    reset = 1'b1;
    cyc(4);

    // Write 0x3C to 0x50
    push(EV_ADDR, 8'h00); push(EV_RX, 8'h3C);
    i2c_start();
    chk("wr busy after start", {31'd0, busy}, 32'd1);
    write_byte(8'hA0, 1'b0, "wr addr ack");
    write_byte(8'h3C, 1'b0, "wr data ack");
    i2c_stop();
    cyc(4);
    chk("wr busy after stop", {31'd0, busy}, 32'd0);
    chk("wr rx_data", {24'd0, rx_data}, 32'h3C);

    // Read two bytes, ACK then NACK
    tx_data = 8'h96;
    push(EV_ADDR, 8'h00); push(EV_LOAD, 8'h96); push(EV_LOAD, 8'h5A);
    i2c_start();
    write_byte(8'hA1, 1'b0, "rd addr ack");
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, r);
      nib[i] = r;
    end
    chk("rd byte0", {24'd0, nib}, 32'h96);
    tx_data = 8'h5A;
    clk_bit(1'b0, r);
    read_byte(8'h5A, 1'b1, "rd byte1");
    chk("rd sda released after nack", {31'd0, sda_oe}, 32'd0);
    chk("rd busy after nack", {31'd0, busy}, 32'd0);
    i2c_stop();
    cyc(4);

    // Foreign address: no reaction for the whole frame
    oe_seen = 1'b0;
    i2c_start();
    write_byte(8'hA2, 1'b1, "miss addr nack");
    write_byte(8'h55, 1'b1, "miss data nack");
    chk("miss busy in ignore", {31'd0, busy}, 32'd0);
    i2c_stop();
    cyc(4);
    chk("miss sda_oe never set", {31'd0, oe_seen}, 32'd0);

    // Write, partial byte, repeated START, then read
    tx_data = 8'h77;
    push(EV_ADDR, 8'h00); push(EV_ADDR, 8'h00); push(EV_LOAD, 8'h77);
    i2c_start();
    write_byte(8'hA0, 1'b0, "rs wr addr ack");
    for (int i = 0; i < 4; i++) clk_bit(i[0], r);
    i2c_start();
    chk("rs busy after restart", {31'd0, busy}, 32'd1);
    write_byte(8'hA1, 1'b0, "rs rd addr ack");
    read_byte(8'h77, 1'b1, "rs rd byte");
    i2c_stop();
    cyc(4);

    // Reset during the address ACK slot
    push(EV_ADDR, 8'h00);
    i2c_start();
    for (int i = 7; i >= 0; i--) clk_bit(nib[0] & 1'b0 | (i == 7 || i == 5), r);
    sda_m = 1'b1;
    cyc(2);
    chk("rst ack driven", {31'd0, sda_oe}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("rst sda_oe async", {31'd0, sda_oe}, 32'd0);
    chk("rst outputs", {20'd0, rx_data, rx_valid, tx_load, addr_hit, busy}, 32'd0);
    scl_m = 1'b1; sda_m = 1'b1;
    cyc(3);
    reset = 1'b1;
    cyc(4);
    push(EV_ADDR, 8'h00); push(EV_RX, 8'h11);
    i2c_start();
    write_byte(8'hA0, 1'b0, "rst2 addr ack");
    write_byte(8'h11, 1'b0, "rst2 data ack");
    i2c_stop();
    cyc(4);
    chk("rst2 rx_data", {24'd0, rx_data}, 32'h11);

    // sample_en held low mid-byte while the lines toggle
    push(EV_ADDR, 8'h00); push(EV_RX, 8'hC5);
    i2c_start();
    write_byte(8'hA0, 1'b0, "hold addr ack");
    nib = 8'hC5;
    for (int i = 7; i >= 4; i--) clk_bit(nib[i], r);
    sample_en = 1'b0;
    for (int i = 0; i < 100; i++) begin
      scl_m = i[2];
      sda_m = i[1];
      cyc(1);
    end
    scl_m = 1'b0; sda_m = 1'b0;
    chk("hold busy", {31'd0, busy}, 32'd1);
    sample_en = 1'b1;
    for (int i = 3; i >= 0; i--) clk_bit(nib[i], r);
    clk_bit(1'b1, r);
    chk("hold data ack", {31'd0, r}, 32'd0);
    i2c_stop();
    cyc(4);
    chk("hold rx_data", {24'd0, rx_data}, 32'hC5);

    tests++;
    if (evq.size() != 0) begin
      fails++;
      $display("FAIL event queue: got %0d events still pending, required 0", evq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
